// File: rtl/stage_execute_md.sv
// Execute stage with X/M pipeline register, feeding the memory stage.
// Single-cycle ALU ops land in X/M at the next edge. Signed mul/div run in an
// iterative shift-add / restoring-divide unit that stalls the front end.
// Optional feature macro: EXEC_MULDIV_EN (defined = iterative mul/div unit,
// undefined = no FSM, stall_out tied low, mul/div complete at once with
// o_out = 0 and ovf_out = 1).
module stage_execute_md #(
    parameter int         XLEN       = 32,
    parameter logic [4:0] NOP_OPCODE = 5'b00000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            valid_in,
    input  logic [4:0]      opcode_in,
    input  logic [4:0]      aluop_in,
    input  logic [4:0]      shamt_in,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [4:0]      rd_in,
    input  logic            flush_in,
    output logic            stall_out,
    output logic            valid_out,
    output logic [4:0]      opcode_out,
    output logic [XLEN-1:0] o_out,
    output logic [XLEN-1:0] b_out,
    output logic [4:0]      rd_out,
    output logic            ovf_out
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] ALU_MUL  = 5'd6;
    localparam logic [4:0] ALU_DIV  = 5'd7;

    logic [XLEN-1:0] sum_ab, diff_ab, sum_ai;
    logic            add_ovf, sub_ovf, addi_ovf;
    logic [XLEN-1:0] alu_o;
    logic            alu_ovf;

    assign sum_ab   = a_in + b_in;
    assign diff_ab  = a_in - b_in;
    assign sum_ai   = a_in + imm_in;
    assign add_ovf  = (a_in[XLEN-1] == b_in[XLEN-1]) && (sum_ab[XLEN-1] != a_in[XLEN-1]);
    assign sub_ovf  = (a_in[XLEN-1] != b_in[XLEN-1]) && (diff_ab[XLEN-1] != a_in[XLEN-1]);
    assign addi_ovf = (a_in[XLEN-1] == imm_in[XLEN-1]) && (sum_ai[XLEN-1] != a_in[XLEN-1]);

    // Single-cycle ALU result and overflow flag
    always_comb begin
        alu_o   = '0;
        alu_ovf = 1'b0;
        case (opcode_in)
            OP_RTYPE: begin
                case (aluop_in)
                    5'd0: begin alu_o = sum_ab;  alu_ovf = add_ovf; end
                    5'd1: begin alu_o = diff_ab; alu_ovf = sub_ovf; end
                    5'd2: alu_o = a_in & b_in;
                    5'd3: alu_o = a_in | b_in;
                    5'd4: alu_o = a_in << shamt_in;
                    5'd5: alu_o = $signed(a_in) >>> shamt_in;
                    ALU_MUL, ALU_DIV: begin
`ifdef EXEC_MULDIV_EN
                        // Result comes from the iterative unit instead
                        alu_o   = '0;
`else
                        alu_o   = '0;
                        alu_ovf = 1'b1;
`endif
                    end
                    default: alu_o = '0;
                endcase
            end
            OP_ADDI: begin alu_o = sum_ai; alu_ovf = addi_ovf; end
            OP_SW, OP_LW: alu_o = sum_ai;
            default: alu_o = '0;
        endcase
    end

`ifdef EXEC_MULDIV_EN
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;      // mul: {partial, multiplier}; div: {rem, quot}
    logic [XLEN-1:0]   den_q, den_d;      // multiplicand / divisor magnitude
    logic              is_div_q, is_div_d;
    logic              neg_q, neg_d;      // result sign differs from magnitude result
    logic              dz_q, dz_d;        // divide by zero
    logic              dovf_q, dovf_d;    // most-negative / -1

    logic              md_op;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum, rem_sh;
    logic [XLEN-1:0]   div_sub;
    logic [2*XLEN-1:0] mul_step, div_step, prod;
    logic [XLEN-1:0]   quot, md_o;
    logic              md_ovf;

    assign md_op = valid_in && (opcode_in == OP_RTYPE) &&
                   ((aluop_in == ALU_MUL) || (aluop_in == ALU_DIV));
    assign stall_out = md_op && (state_q != S_DONE) && !flush_in;

    assign a_mag = a_in[XLEN-1] ? -a_in : a_in;
    assign b_mag = b_in[XLEN-1] ? -b_in : b_in;

    // One iteration of each algorithm on the unsigned magnitudes
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, den_q} : '0);
    assign mul_step = {mul_sum, acc_q[XLEN-1:1]};
    assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_sub  = rem_sh[XLEN-1:0] - den_q;
    assign div_step = (rem_sh >= {1'b0, den_q}) ? {div_sub, acc_q[XLEN-2:0], 1'b1}
                                                : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

    // Sign correction and flags for the finished mul/div
    always_comb begin
        prod   = neg_q ? -acc_q : acc_q;
        quot   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        md_o   = '0;
        md_ovf = 1'b0;
        if (is_div_q) begin
            md_o   = dz_q ? '0 : quot;
            md_ovf = dz_q || dovf_q;
        end else begin
            md_o   = prod[XLEN-1:0];
            md_ovf = prod[2*XLEN-1:XLEN] != {XLEN{prod[XLEN-1]}};
        end
    end

    // Mul/div FSM next state and operand/accumulator updates
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        den_d    = den_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        dovf_d   = dovf_q;
        if (flush_in) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (md_op) begin
                        state_d  = S_BUSY;
                        cnt_d    = '0;
                        acc_d    = {{XLEN{1'b0}}, a_mag};
                        den_d    = b_mag;
                        is_div_d = (aluop_in == ALU_DIV);
                        neg_d    = a_in[XLEN-1] ^ b_in[XLEN-1];
                        dz_d     = (b_in == '0);
                        dovf_d   = (a_in == {1'b1, {(XLEN-1){1'b0}}}) && (b_in == '1);
                    end
                end
                S_BUSY: begin
                    acc_d = is_div_q ? div_step : mul_step;
                    if (cnt_q == CNT_W'(XLEN-1)) state_d = S_DONE;
                    else                         cnt_d   = cnt_q + 1'b1;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Mul/div FSM and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            den_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            dovf_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            den_q    <= den_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            dovf_q   <= dovf_d;
        end
    end
`else
    assign stall_out = 1'b0;
`endif

    logic            valid_d;
    logic [4:0]      opcode_d, rd_d;
    logic [XLEN-1:0] o_d, b_d;
    logic            ovf_d;

    // X/M next value: bubble on flush, empty slot or stall, else the result
    always_comb begin
        valid_d  = 1'b0;
        opcode_d = NOP_OPCODE;
        o_d      = '0;
        b_d      = '0;
        rd_d     = '0;
        ovf_d    = 1'b0;
        if (valid_in && !flush_in && !stall_out) begin
            valid_d  = 1'b1;
            opcode_d = opcode_in;
            b_d      = b_in;
            rd_d     = rd_in;
            o_d      = alu_o;
            ovf_d    = alu_ovf;
`ifdef EXEC_MULDIV_EN
            // Unstalled md op here means the FSM is in DONE
            if (md_op) begin
                o_d   = md_o;
                ovf_d = md_ovf;
            end
`endif
        end
    end

    // X/M pipeline register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_out  <= 1'b0;
            opcode_out <= NOP_OPCODE;
            o_out      <= '0;
            b_out      <= '0;
            rd_out     <= '0;
            ovf_out    <= 1'b0;
        end else begin
            valid_out  <= valid_d;
            opcode_out <= opcode_d;
            o_out      <= o_d;
            b_out      <= b_d;
            rd_out     <= rd_d;
            ovf_out    <= ovf_d;
        end
    end

endmodule
